// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_pkg
// Purpose  : Shared types and constants for the arithmetic library.
// Revision : 1.0 - initial release
// ============================================================================
package arith_pkg;

  localparam int ARITH_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_div8_sub_bla.sv
`default_nettype none
// ============================================================================
// Module   : sub_bla
// Purpose  : N-bit borrow-lookahead subtractor, diff = a - b - bin.
// Revision : 1.0 - initial release
// ============================================================================
module sub_bla #(
  parameter int N = 9
) (
  output logic [N-1:0] diff_o,
  output logic         bout_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         bin_i
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   bor;

  // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
  generate
    for (genvar i = 0; i < N; i++) begin : g_bit
      assign gen[i]    = ~a_i[i] & b_i[i];
      assign prop[i]   = ~(a_i[i] ^ b_i[i]);
      assign diff_o[i] = a_i[i] ^ b_i[i] ^ bor[i];
    end
  endgenerate

  // Each borrow is a flat sum of products over all lower generate/propagate terms.
  always_comb begin
    logic pp;
    bor    = '0;
    pp     = 1'b1;
    bor[0] = bin_i;
    for (int i = 0; i < N; i++) begin
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        bor[i+1] = bor[i+1] | (pp & gen[j]);
        pp       = pp & prop[j];
      end
      bor[i+1] = bor[i+1] | (pp & bin_i);
    end
  end

  assign bout_o = bor[N];

endmodule
`default_nettype wire

// File: rtl/seq_div8.sv
`default_nettype none
// ============================================================================
// Module   : seq_div8
// Purpose  : Sequential restoring unsigned divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div8
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             div_zero;
  logic             last_step;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   t_diff;
  logic             t_borrow;
  logic             unused_r_msb;

  assign div_zero  = (divisor == '0);
  assign accept    = start && (state_q != RUN);
  assign last_step = (cnt_q == LAST_STEP);
  assign r_shift   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  // The partial remainder stays below the divisor, so its MSB never reaches the next shift.
  assign unused_r_msb = r_q[WIDTH];

  sub_bla #(
    .N(WIDTH + 1)
  ) u_sub (
    .diff_o (t_diff),
    .bout_o (t_borrow),
    .a_i    (r_shift),
    .b_i    ({1'b0, d_q}),
    .bin_i  (1'b0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = div_zero ? DONE : RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = start ? (div_zero ? DONE : RUN) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    q_d    = q_q;
    d_d    = d_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (accept) begin
      if (div_zero) begin
        quot_d = '1;
        rem_d  = dividend;
        dbz_d  = 1'b1;
      end else begin
        q_d   = dividend;
        d_d   = divisor;
        r_d   = '0;
        cnt_d = '0;
        dbz_d = 1'b0;
      end
    end else if (state_q == RUN) begin
      r_d   = t_borrow ? r_shift : t_diff;
      q_d   = {q_q[WIDTH-2:0], ~t_borrow};
      cnt_d = cnt_q + 1'b1;
      if (last_step) begin
        quot_d = q_d;
        rem_d  = r_d[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      d_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      d_q    <= d_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_div8.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_div8
// Purpose  : Directed-vector and sweep bench for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_div8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       dbz;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
    int         bcnt;
  } vec_t;

  vec_t tbl[6];

  seq_div8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Entered at the negedge right after the accepting edge; lat counts edges until done.
  task automatic wait_done(input int pulse_at, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      if (lat == pulse_at) begin
        start    = 1'b1;
        dividend = 8'd1;
        divisor  = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int bcnt;
    logic [7:0] ra;
    logic [7:0] rb;

    tbl[0] = '{a: 8'd200, b: 8'd7, q: 8'd28,  r: 8'd4,   z: 1'b0, lat: 8, bcnt: 8};
    tbl[1] = '{a: 8'd255, b: 8'd1, q: 8'd255, r: 8'd0,   z: 1'b0, lat: 8, bcnt: 8};
    tbl[2] = '{a: 8'd5,   b: 8'd9, q: 8'd0,   r: 8'd5,   z: 1'b0, lat: 8, bcnt: 8};
    tbl[3] = '{a: 8'd0,   b: 8'd3, q: 8'd0,   r: 8'd0,   z: 1'b0, lat: 8, bcnt: 8};
    tbl[4] = '{a: 8'd100, b: 8'd0, q: 8'd255, r: 8'd100, z: 1'b1, lat: 0, bcnt: 0};
    tbl[5] = '{a: 8'd9,   b: 8'd3, q: 8'd3,   r: 8'd0,   z: 1'b0, lat: 8, bcnt: 8};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_q",    {24'd0, quotient}, 32'd0);
    check("reset_r",    {24'd0, remainder}, 32'd0);
    check("reset_dbz",  {31'd0, dbz}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].a, tbl[i].b);
      wait_done(-1, lat, bcnt);
      check($sformatf("tbl%0d_q", i),    {24'd0, quotient},  {24'd0, tbl[i].q});
      check($sformatf("tbl%0d_r", i),    {24'd0, remainder}, {24'd0, tbl[i].r});
      check($sformatf("tbl%0d_dbz", i),  {31'd0, dbz},       {31'd0, tbl[i].z});
      check($sformatf("tbl%0d_lat", i),  lat,  tbl[i].lat);
      check($sformatf("tbl%0d_busy", i), bcnt, tbl[i].bcnt);
      @(negedge clk);
      check($sformatf("tbl%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Back-to-back: start held into DONE with the next operands.
    launch(8'd200, 8'd7);
    wait_done(-1, lat, bcnt);
    check("b2b_first_lat", lat, 8);
    check("b2b_first_q", {24'd0, quotient}, 32'd28);
    dividend = 8'd17;
    divisor  = 8'd4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_again", {31'd0, busy}, 32'd1);
    wait_done(-1, lat, bcnt);
    check("b2b_second_lat", lat, 8);
    check("b2b_second_q", {24'd0, quotient}, 32'd4);
    check("b2b_second_r", {24'd0, remainder}, 32'd1);
    @(negedge clk);

    // A start pulsed mid-RUN must be ignored.
    launch(8'd200, 8'd7);
    wait_done(3, lat, bcnt);
    check("midrun_lat", lat, 8);
    check("midrun_q", {24'd0, quotient}, 32'd28);
    check("midrun_r", {24'd0, remainder}, 32'd4);
    @(negedge clk);
    check("midrun_idle", {30'd0, busy, done}, 32'd0);

    // Asynchronous reset during step 4 of 200/7.
    launch(8'd200, 8'd7);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    check("rst_run_done", {31'd0, done}, 32'd0);
    check("rst_run_q",    {24'd0, quotient}, 32'd0);
    check("rst_run_r",    {24'd0, remainder}, 32'd0);
    check("rst_run_dbz",  {31'd0, dbz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(8'd50, 8'd6);
    wait_done(-1, lat, bcnt);
    check("post_rst_lat", lat, 8);
    check("post_rst_q", {24'd0, quotient}, 32'd8);
    check("post_rst_r", {24'd0, remainder}, 32'd2);
    @(negedge clk);

    for (int k = 0; k < 2000; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      launch(ra, rb);
      wait_done(-1, lat, bcnt);
      check("rand_q", {24'd0, quotient},  {24'd0, ra / rb});
      check("rand_r", {24'd0, remainder}, {24'd0, ra % rb});
      check("rand_lat", lat, 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
